// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole round sequencer; LFSR mole pick, window timing, scoring and game end.
module mole_round_ctrl #(
    parameter int          N_MOLES     = 10,
    parameter int          WINDOW_INIT = 50_000_000,
    parameter int          WINDOW_MIN  = 10_000_000,
    parameter int          WINDOW_STEP = 2_000_000,
    parameter int          GAP_CYCLES  = 12_500_000,
    parameter int          ROUNDS      = 30,
    parameter int          MAX_MISSES  = 3,
    parameter int          RESOLVE_TMO = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [N_MOLES-1:0] active_onehot,
    output logic               led_toggle,
    output logic [7:0]         score,
    output logic [3:0]         misses,
    output logic [7:0]         round_idx,
    output logic               busy,
    output logic               game_over
);
    localparam int WW    = $clog2(WINDOW_INIT + 1);
    localparam int CMAX0 = WINDOW_INIT > GAP_CYCLES ? WINDOW_INIT : GAP_CYCLES;
    localparam int CMAX  = CMAX0 > RESOLVE_TMO ? CMAX0 : RESOLVE_TMO;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int IW    = $clog2(N_MOLES + 1);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GAP     = 3'd1;
    localparam logic [2:0] LIT     = 3'd2;
    localparam logic [2:0] RESOLVE = 3'd3;
    localparam logic [2:0] OVER    = 3'd4;
    logic [2:0]    state;
    logic [15:0]   lfsr;
    logic [IW-1:0] prev_idx, raw_idx, pick_idx;
    logic [CW-1:0] cnt;
    logic [WW-1:0] window, window_dec;
    logic [7:0]    score_n;
    logic [3:0]    misses_n;
    logic          hit_ev, miss_ev, finish;
    // Counts used for the end-of-game decision are the post-verdict values.
    always_comb begin
        raw_idx    = IW'(lfsr[7:0] % 8'(N_MOLES));
        pick_idx   = (raw_idx != prev_idx) ? raw_idx :
                     (raw_idx == IW'(N_MOLES - 1)) ? '0 : raw_idx + 1'b1;
        hit_ev     = hit_pulse && (state == LIT || state == RESOLVE);
        miss_ev    = !hit_pulse && state == RESOLVE && (miss_pulse || cnt == '0);
        score_n    = (hit_ev && score != 8'hff) ? score + 8'd1 : score;
        misses_n   = miss_ev ? misses + 4'd1 : misses;
        window_dec = (int'(window) >= WINDOW_MIN + WINDOW_STEP) ? window - WW'(WINDOW_STEP)
                                                                 : WW'(WINDOW_MIN);
        finish     = misses_n == 4'(MAX_MISSES) || round_idx == 8'(ROUNDS);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lfsr          <= LFSR_SEED;
            prev_idx      <= IW'(N_MOLES);
            cnt           <= '0;
            window        <= WW'(WINDOW_INIT);
            active_onehot <= '0;
            led_toggle    <= 1'b0;
            score         <= '0;
            misses        <= '0;
            round_idx     <= '0;
            busy          <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            led_toggle <= 1'b0;
            if (hit_ev || miss_ev) begin
                score         <= score_n;
                misses        <= misses_n;
                active_onehot <= '0;
                state         <= finish ? OVER : GAP;
                cnt           <= CW'(GAP_CYCLES - 1);
                busy          <= !finish;
                game_over     <= finish;
                if (hit_ev) window <= window_dec;
            end else begin
                case (state)
                    IDLE, OVER: if (start) begin
                        state     <= GAP;
                        cnt       <= CW'(GAP_CYCLES - 1);
                        score     <= '0;
                        misses    <= '0;
                        round_idx <= '0;
                        window    <= WW'(WINDOW_INIT);
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                    end
                    GAP: if (cnt == '0) begin
                        prev_idx      <= pick_idx;
                        active_onehot <= N_MOLES'(1) << pick_idx;
                        round_idx     <= round_idx + 8'd1;
                        cnt           <= CW'(window) - 1'b1;
                        led_toggle    <= window == WW'(1);
                        state         <= LIT;
                    end else cnt <= cnt - 1'b1;
                    // led_toggle is registered, so it is raised one cycle ahead of the last lit cycle.
                    LIT: if (cnt == '0) begin
                        state <= RESOLVE;
                        cnt   <= CW'(RESOLVE_TMO - 1);
                    end else begin
                        cnt        <= cnt - 1'b1;
                        led_toggle <= cnt == CW'(1);
                    end
                    RESOLVE: cnt <= cnt - 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: directed stimulus with a verdict scoreboard and an LED-selection monitor.
module tb_mole_round_ctrl;
    localparam int N = 10, WI = 20, WMIN = 8, WSTEP = 5, GAP = 4, RND = 30, MAXM = 3, TMO = 8;
    logic clk = 0, rst = 1, start = 0, hit_pulse = 0, miss_pulse = 0;
    logic [N-1:0] active_onehot;
    logic led_toggle, busy, game_over;
    logic [7:0] score, round_idx;
    logic [3:0] misses;

    mole_round_ctrl #(.N_MOLES(N), .WINDOW_INIT(WI), .WINDOW_MIN(WMIN), .WINDOW_STEP(WSTEP),
        .GAP_CYCLES(GAP), .ROUNDS(RND), .MAX_MISSES(MAXM), .RESOLVE_TMO(TMO), .LFSR_SEED(16'hACE1))
    dut (.clk(clk), .rst(rst), .start(start), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .active_onehot(active_onehot), .led_toggle(led_toggle), .score(score), .misses(misses),
        .round_idx(round_idx), .busy(busy), .game_over(game_over));

    always #5 clk = ~clk;

    typedef struct {int score; int misses; int rnd; int over; int busy; int lit; int tog;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;
    int e_score, e_miss, e_round, e_win;
    logic [15:0] m_lfsr = '0, m_d1 = '0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // reference LFSR: 16-bit Fibonacci, taps 16,14,13,11
    always @(posedge clk) begin
        m_d1   <= m_lfsr;
        m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // monitor: checks each new mole and pops one record whenever the LED goes dark
    int mon_lit = 0, mon_tog = 0, mon_prev = N, mon_idx = 0;
    logic [N-1:0] mon_last = '0, mon_act = '0;
    exp_t mon_e;
    initial forever begin
        @(posedge clk);
        #1;
        if (active_onehot != '0) begin
            if (mon_act == '0) begin
                mon_lit = 0;
                mon_tog = 0;
                mon_idx = int'(m_d1[7:0]) % N;
                if (mon_idx == mon_prev) mon_idx = (mon_idx + 1) % N;
                mon_prev = mon_idx;
                chk("onehot", int'($onehot(active_onehot)), 1);
                chk("no_repeat", int'(active_onehot != mon_last), 1);
                chk("mole_idx", int'(active_onehot), 1 << mon_idx);
                mon_last = active_onehot;
            end
            mon_lit++;
            if (led_toggle) mon_tog = mon_lit;
        end else if (mon_act != '0) begin
            chk("queue_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("score", score, mon_e.score);
                chk("misses", misses, mon_e.misses);
                chk("round_idx", round_idx, mon_e.rnd);
                chk("game_over", game_over, mon_e.over);
                chk("busy", busy, mon_e.busy);
                chk("lit_cycles", mon_lit, mon_e.lit);
                chk("toggle_cycle", mon_tog, mon_e.tog);
            end
        end
        if (rst) begin
            mon_prev = N;
            mon_last = '0;
        end
        mon_act = active_onehot;
    end

    task automatic check_idle(string tag);
        chk({tag, "_active"}, int'(active_onehot), 0);
        chk({tag, "_toggle"}, led_toggle, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_misses"}, misses, 0);
        chk({tag, "_round"}, round_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        e_score = 0;
        e_miss  = 0;
        e_round = 0;
        e_win   = WI;
        chk("start_busy", busy, 1);
        chk("start_over", game_over, 0);
        chk("start_score", score, 0);
        chk("start_misses", misses, 0);
        chk("start_round", round_idx, 0);
    endtask

    task automatic wait_led(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (active_onehot == '0 && n < 200);
    endtask

    // mode 0: hit at lit cycle 'at'; 1: miss after toggle; 2: silent timeout;
    // 3: hit after toggle; 4: hit+miss after toggle; 5: hit+miss at lit cycle 'at'
    task automatic mole(input int mode, input int at, input bit st);
        int n, w, lit, tog;
        bit hit;
        exp_t e;
        wait_led(n);
        chk("gap_cycles", n, GAP);
        w = e_win;
        e_round++;
        hit = mode != 1 && mode != 2;
        lit = (mode == 0 || mode == 5) ? at : (mode == 2 ? w + TMO : w + 1);
        tog = (mode == 0 || mode == 5) ? (at == w ? w : 0) : w;
        if (hit) begin
            e_score = e_score < 255 ? e_score + 1 : 255;
            e_win   = (e_win - WSTEP < WMIN) ? WMIN : e_win - WSTEP;
        end else e_miss++;
        e.score  = e_score;
        e.misses = e_miss;
        e.rnd    = e_round;
        e.over   = (e_miss == MAXM || e_round == RND) ? 1 : 0;
        e.busy   = 1 - e.over;
        e.lit    = lit;
        e.tog    = tog;
        q.push_back(e);
        case (mode)
            0, 5: begin
                if (st) begin
                    start = 1;
                    @(negedge clk);
                    start = 0;
                    repeat (at - 2) @(negedge clk);
                end else repeat (at - 1) @(negedge clk);
                hit_pulse  = 1;
                miss_pulse = (mode == 5);
                @(negedge clk);
                hit_pulse  = 0;
                miss_pulse = 0;
            end
            2: repeat (w + TMO) @(negedge clk);
            default: begin
                repeat (w) @(negedge clk);
                hit_pulse  = (mode != 1);
                miss_pulse = (mode != 3);
                @(negedge clk);
                hit_pulse  = 0;
                miss_pulse = 0;
            end
        endcase
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t r;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        check_idle("reset");
        do_start();
        // game 1: hit, misses, ignored start, simultaneous verdicts, end on misses
        mole(0, 3, 0);
        mole(1, 0, 0);
        mole(0, 4, 1);
        mole(4, 0, 0);
        mole(5, 2, 0);
        mole(2, 0, 0);
        mole(1, 0, 0);
        chk("over_flag", game_over, 1);
        chk("over_busy", busy, 0);
        hit_pulse  = 1;
        miss_pulse = 1;
        @(negedge clk);
        hit_pulse  = 0;
        miss_pulse = 0;
        repeat (5) @(negedge clk);
        chk("over_active", int'(active_onehot), 0);
        chk("over_score_frozen", score, 4);
        chk("over_misses_frozen", misses, 3);
        chk("over_round_frozen", round_idx, 7);
        chk("over_flag_held", game_over, 1);
        // game 2: window floor, then reset in the middle of a lit window
        do_start();
        repeat (5) mole(3, 0, 0);
        wait_led(n);
        chk("gap_cycles", n, GAP);
        r = '{score: 0, misses: 0, rnd: 0, over: 0, busy: 0, lit: 3, tog: 0};
        q.push_back(r);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        check_idle("midgame_reset");
        repeat (10) @(negedge clk);
        check_idle("idle_hold");
        // game 3: round limit with all hits
        do_start();
        repeat (RND) mole(0, 1, 0);
        chk("rounds_over", game_over, 1);
        chk("rounds_score", score, RND);
        // more games for selection coverage
        for (int g = 0; g < 6; g++) begin
            do_start();
            for (int k = 0; k < RND; k++)
                mole(k == 10 ? 1 : k == 20 ? 4 : k == 25 ? 2 : 0, 1 + k % 3, 0);
            chk("game_over_end", game_over, 1);
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
